imem_program_loader: RTL and testbench

- Fills InstructionMemory with a program before the RISC core runs.
- Consumes a byte stream with a valid/ready handshake, assembles big-endian 32-bit words, and drives InstructionMemory's write port (4-bit write enable, byte address, 32-bit write data).
- Holds the core in reset until the load completes.
- Acts as the writer side of the memory the processor only reads.

---
 rtl/imem_program_loader.sv | 200 ++++++++++++++++++++
 tb/tb_imem_program_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// imem_program_loader: fills InstructionMemory from a big-endian byte stream
// and holds the core in reset until the program image is complete.
//
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   start               pulse; begins a load from IDLE, DONE or ERR
//   rx_data/valid/ready byte stream handshake (accept = valid & ready)
//   im_we/addr/wdata    InstructionMemory write port
//   cpu_hold            active-high reset for the processor
//   busy/done/err       load status (done and err are levels)
//   words_loaded        words written in the current load
module imem_program_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [3:0]  im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_BYTE,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // 17 bits so a length of 65535 compares correctly against any limit
    // up to 65536.
    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        rx_ready_q, rx_ready_d;
    logic [3:0]  im_we_q, im_we_d;
    logic [31:0] im_addr_q, im_addr_d;
    logic [31:0] im_wdata_q, im_wdata_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] words_q, words_d;

    logic        accept;
    logic [15:0] n_full;
    logic [15:0] words_inc;

    assign accept    = rx_valid & rx_ready_q;
    assign n_full    = {n_q[15:8], rx_data};
    assign words_inc = words_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        rx_ready_d = rx_ready_q;
        im_we_d    = 4'b0000;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        cpu_hold_d = cpu_hold_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        words_d    = words_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    n_d        = 16'd0;
                    cnt_d      = 2'd0;
                    rx_ready_d = 1'b1;
                    im_addr_d  = BASE_ADDR;
                    cpu_hold_d = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    words_d    = 16'd0;
                end
            end

            S_LEN_HI: begin
                if (accept) begin
                    n_d[15:8] = rx_data;
                    state_d   = S_LEN_LO;
                end
            end

            S_LEN_LO: begin
                if (accept) begin
                    n_d = n_full;
                    if (n_full == 16'd0) begin
                        state_d    = S_DONE;
                        rx_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else if ({1'b0, n_full} > MAX_N) begin
                        state_d    = S_ERR;
                        rx_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        err_d      = 1'b1;
                    end else begin
                        state_d = S_BYTE;
                    end
                end
            end

            S_BYTE: begin
                if (accept) begin
                    // The word register is the write-data output itself;
                    // first byte of a word ends up in bits [31:24].
                    im_wdata_d = {im_wdata_q[23:0], rx_data};
                    if (cnt_q == 2'd3) begin
                        cnt_d      = 2'd0;
                        state_d    = S_WRITE;
                        im_we_d    = 4'b1111;
                        rx_ready_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end

            S_WRITE: begin
                im_addr_d = im_addr_q + 32'd4;
                words_d   = words_inc;
                if (words_inc == n_q) begin
                    state_d    = S_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end else begin
                    state_d    = S_BYTE;
                    rx_ready_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            n_q        <= 16'd0;
            cnt_q      <= 2'd0;
            rx_ready_q <= 1'b0;
            im_we_q    <= 4'b0000;
            im_addr_q  <= BASE_ADDR;
            im_wdata_q <= 32'd0;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            rx_ready_q <= rx_ready_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            cpu_hold_q <= cpu_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            words_q    <= words_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign im_we        = im_we_q;
    assign im_addr      = im_addr_q;
    assign im_wdata     = im_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: table-driven and randomized checks of the
// program loader against a queue-based model of the expected memory image.
module tb_imem_program_loader;

    localparam int          MAXW = 256;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [3:0]  im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    imem_program_loader #(
        .MAX_WORDS(MAXW),
        .BASE_ADDR(BASE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .im_we(im_we),
        .im_addr(im_addr),
        .im_wdata(im_wdata),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .done(done),
        .err(err),
        .words_loaded(words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int bad_we = 0;
    logic [63:0] wq[$];

    // Observed memory writes, sampled mid-cycle.
    always @(negedge clock) begin
        if (im_we == 4'hF) wq.push_back({im_addr, im_wdata});
        else if (im_we != 4'h0) bad_we++;
    end

    typedef struct {
        int n;
        int gap;
        int stray;
        bit done_e;
        bit err_e;
        int words_e;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Presents bytes one at a time, holding each until accepted.
    // gap 0: valid always; 1: valid pattern 1,0,0,1; 2: random.
    task automatic feed(input logic [7:0] q[$], input int gap,
                        input int stray_at);
        int i = 0;
        int t = 0;
        bit acc;
        while (i < q.size() && t < 6000) begin
            @(negedge clock);
            start   = (stray_at >= 0 && i == stray_at);
            rx_data = q[i];
            case (gap)
                0: rx_valid = 1'b1;
                1: rx_valid = (t % 4 == 0) || (t % 4 == 3);
                default: rx_valid = ($urandom % 4) != 0;
            endcase
            acc = rx_valid && rx_ready;
            t++;
            @(posedge clock);
            if (acc) i++;
        end
        chk("feed_accepted", i, q.size());
        @(negedge clock);
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int c = 0;
        while (!(done || err) && c < 50) begin
            @(negedge clock);
            c++;
        end
        chk({nm, "_ended"}, done | err, 1);
    endtask

    // Full load with random payload; writes checked against the model:
    // word i at BASE+4i holds payload bytes 4i..4i+3, MSB first.
    task automatic run_load(input string nm, input int n, input int gap,
                            input int stray_at, input bit done_e,
                            input bit err_e, input int words_e);
        logic [7:0]  s[$];
        logic [7:0]  pay[$];
        logic [15:0] nn;
        logic [31:0] w;
        int          nw;
        nn = n[15:0];
        s.push_back(nn[15:8]);
        s.push_back(nn[7:0]);
        nw = (n > MAXW) ? 0 : n;
        for (int i = 0; i < 4 * nw; i++) pay.push_back(8'($urandom));
        foreach (pay[i]) s.push_back(pay[i]);
        wq.delete();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        feed(s, gap, stray_at);
        wait_end(nm);
        repeat (2) @(negedge clock);
        chk({nm, "_done"}, done, done_e);
        chk({nm, "_err"}, err, err_e);
        chk({nm, "_words"}, words_loaded, words_e);
        chk({nm, "_hold"}, cpu_hold, !done_e);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_ready"}, rx_ready, 0);
        chk({nm, "_nwrites"}, wq.size(), nw);
        for (int i = 0; i < nw && i < wq.size(); i++) begin
            w = {pay[4*i], pay[4*i+1], pay[4*i+2], pay[4*i+3]};
            chk($sformatf("%s_w%0d", nm, i), wq[i],
                {BASE + 32'(4 * i), w});
        end
    endtask

    initial begin
        logic [7:0] q2[$];
        logic [7:0] qp[$];
        int e;
        int n;
        bit big;

        tbl[0] = '{2,     0, -1,  1'b1, 1'b0, 2};
        tbl[1] = '{0,     0, -1,  1'b1, 1'b0, 0};
        tbl[2] = '{257,   0, -1,  1'b0, 1'b1, 0};
        tbl[3] = '{1,     0, -1,  1'b1, 1'b0, 1};
        tbl[4] = '{1,     1, -1,  1'b1, 1'b0, 1};
        tbl[5] = '{256,   0, 100, 1'b1, 1'b0, 256};
        tbl[6] = '{5,     2, 7,   1'b1, 1'b0, 5};
        tbl[7] = '{65535, 0, -1,  1'b0, 1'b1, 0};

        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clock);
        chk("rst_ready", rx_ready, 0);
        chk("rst_we", im_we, 0);
        chk("rst_addr", im_addr, BASE);
        chk("rst_wdata", im_wdata, 0);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_words", words_loaded, 0);
        reset = 1'b1;
        @(negedge clock);

        // Basic two-word load with exact latency.
        q2 = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
               8'h8C, 8'h22, 8'h00, 8'h00};
        wq.delete();
        start = 1'b1;
        @(posedge clock);
        e = 1;
        fork
            feed(q2, 0, -1);
            begin
                @(negedge clock);
                chk("basic_busy", busy, 1);
                chk("basic_hold", cpu_hold, 1);
                chk("basic_ready", rx_ready, 1);
                while (!done && e < 40) begin
                    @(posedge clock);
                    e++;
                    @(negedge clock);
                end
            end
        join
        chk("basic_latency", e, 13);
        chk("basic_nwrites", wq.size(), 2);
        if (wq.size() >= 2) begin
            chk("basic_w0", wq[0], {BASE, 32'h2001_0005});
            chk("basic_w1", wq[1], {BASE + 32'd4, 32'h8C22_0000});
        end
        chk("basic_words", words_loaded, 2);
        chk("basic_hold_off", cpu_hold, 0);

        // Table of loads; entry 3 restarts from the ERR left by entry 2.
        foreach (tbl[i])
            run_load($sformatf("vec%0d", i), tbl[i].n, tbl[i].gap,
                     tbl[i].stray, tbl[i].done_e, tbl[i].err_e,
                     tbl[i].words_e);

        // Reset after the 2nd byte of word 1 of a 3-word load.
        qp = '{8'h00, 8'h03, 8'hAA, 8'hBB};
        wq.delete();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        feed(qp, 0, -1);
        #1 reset = 1'b0;
        #1;
        chk("mid_ready", rx_ready, 0);
        chk("mid_we", im_we, 0);
        chk("mid_addr", im_addr, BASE);
        chk("mid_wdata", im_wdata, 0);
        chk("mid_hold", cpu_hold, 1);
        chk("mid_busy", busy, 0);
        chk("mid_words", words_loaded, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("mid_nwrites", wq.size(), 0);
        run_load("reload3", 3, 0, -1, 1'b1, 1'b0, 3);

        // Randomized loads.
        for (int r = 0; r < 12; r++) begin
            if ($urandom % 6 == 0) n = MAXW + 1 + int'($urandom % 300);
            else n = int'($urandom % 12);
            big = n > MAXW;
            run_load($sformatf("rnd%0d", r), n, int'($urandom % 3),
                     ($urandom % 2 == 0) ? int'($urandom % (2 + 4 * n)) : -1,
                     !big, big, big ? 0 : n);
        end

        chk("illegal_we", bad_we, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
